// File: rtl/gray_convert_cfg_if.sv
// gray_convert_cfg_if: DVP pixel input, config and gray output bundle
// Ports (signals): dvp_vsync/href/valid/data + cfg_mode/bin_en/thresh into the
// converter; gray_vsync/href/valid/data/bin/x/y out of it.
// master = pixel source / sink side, slave = converter side.
interface gray_convert_cfg_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int X_W    = 11,
    parameter int Y_W    = 10
);
    logic              dvp_vsync;
    logic              dvp_href;
    logic              dvp_valid;
    logic [DATA_W-1:0] dvp_data;
    logic [1:0]        cfg_mode;
    logic              cfg_bin_en;
    logic [OUT_W-1:0]  cfg_thresh;
    logic              gray_vsync;
    logic              gray_href;
    logic              gray_valid;
    logic [OUT_W-1:0]  gray_data;
    logic              gray_bin;
    logic [X_W-1:0]    gray_x;
    logic [Y_W-1:0]    gray_y;
    modport master (
        output dvp_vsync, dvp_href, dvp_valid, dvp_data, cfg_mode, cfg_bin_en, cfg_thresh,
        input  gray_vsync, gray_href, gray_valid, gray_data, gray_bin, gray_x, gray_y
    );
    modport slave (
        input  dvp_vsync, dvp_href, dvp_valid, dvp_data, cfg_mode, cfg_bin_en, cfg_thresh,
        output gray_vsync, gray_href, gray_valid, gray_data, gray_bin, gray_x, gray_y
    );
endinterface

// File: rtl/gray_convert_cfg.sv
// gray_convert_cfg: 3-stage RGB565/RGB888 to gray converter with frame-latched config
// Ports: clk (rising edge), rst_n (async active-low),
//        bus (slave): dvp_* pixel stream and cfg_* in, gray_* stream, binarize flag
//        and pixel coordinates out, all delayed by exactly 3 cycles.
module gray_convert_cfg #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int X_W    = 11,
    parameter int Y_W    = 10,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    gray_convert_cfg_if.slave bus
);
    localparam logic [15:0] RND = (ROUND != 0) ? 16'(1 << (15 - OUT_W)) : 16'd0;
    logic             r_vs_d, r_hr_d;
    logic [1:0]       r_mode;
    logic             r_bin_en;
    logic [OUT_W-1:0] r_thresh;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [2:0]       r1_ctl, r2_ctl;
    logic [7:0]       r1_r, r1_g, r1_b;
    logic [8:0]       r1_wr, r1_wg, r1_wb;
    logic [X_W-1:0]   r1_x, r2_x;
    logic [Y_W-1:0]   r1_y, r2_y;
    logic             r1_bin_en, r2_bin_en;
    logic [OUT_W-1:0] r1_thresh, r2_thresh;
    logic [15:0]      r2_pr, r2_pg, r2_pb;
    logic             w_vs_rise, w_hr_fall, w_bin_en, w_bin;
    logic [1:0]       w_mode;
    logic [OUT_W-1:0] w_thresh, w_gray;
    logic [7:0]       w_r8, w_g8, w_b8;
    logic [8:0]       w_wr, w_wg, w_wb;
    logic [15:0]      w_sum;
    assign w_vs_rise = bus.dvp_vsync & ~r_vs_d;
    assign w_hr_fall = r_hr_d & ~bus.dvp_href;
    // The pixel arriving with the vsync rise already uses the incoming config.
    assign w_mode    = w_vs_rise ? bus.cfg_mode   : r_mode;
    assign w_bin_en  = w_vs_rise ? bus.cfg_bin_en : r_bin_en;
    assign w_thresh  = w_vs_rise ? bus.cfg_thresh : r_thresh;
    generate
        if (DATA_W == 24) begin : g_888
            assign w_r8 = bus.dvp_data[23:16];
            assign w_g8 = bus.dvp_data[15:8];
            assign w_b8 = bus.dvp_data[7:0];
        end else begin : g_565
            assign w_r8 = {bus.dvp_data[15:11], bus.dvp_data[15:13]};
            assign w_g8 = {bus.dvp_data[10:5], bus.dvp_data[10:9]};
            assign w_b8 = {bus.dvp_data[4:0], bus.dvp_data[4:2]};
        end
    endgenerate
    assign w_wr = (w_mode == 2'd0) ? 9'd77  : (w_mode == 2'd1) ? 9'd54  : (w_mode == 2'd2) ? 9'd85 : 9'd0;
    assign w_wg = (w_mode == 2'd0) ? 9'd150 : (w_mode == 2'd1) ? 9'd183 : (w_mode == 2'd2) ? 9'd86 : 9'd256;
    assign w_wb = (w_mode == 2'd0) ? 9'd29  : (w_mode == 2'd1) ? 9'd19  : (w_mode == 2'd2) ? 9'd85 : 9'd0;
    // Weights sum to 256, so the 16-bit sum plus rounding bias cannot overflow.
    assign w_sum  = r2_pr + r2_pg + r2_pb + RND;
    assign w_gray = OUT_W'(w_sum >> (16 - OUT_W));
    assign w_bin  = w_gray >= r2_thresh;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d         <= 1'b0;
            r_hr_d         <= 1'b0;
            r_mode         <= '0;
            r_bin_en       <= 1'b0;
            r_thresh       <= '0;
            r_x            <= '0;
            r_y            <= '0;
            r1_ctl         <= '0;
            r1_r           <= '0;
            r1_g           <= '0;
            r1_b           <= '0;
            r1_wr          <= '0;
            r1_wg          <= '0;
            r1_wb          <= '0;
            r1_x           <= '0;
            r1_y           <= '0;
            r1_bin_en      <= 1'b0;
            r1_thresh      <= '0;
            r2_ctl         <= '0;
            r2_pr          <= '0;
            r2_pg          <= '0;
            r2_pb          <= '0;
            r2_x           <= '0;
            r2_y           <= '0;
            r2_bin_en      <= 1'b0;
            r2_thresh      <= '0;
            bus.gray_vsync <= 1'b0;
            bus.gray_href  <= 1'b0;
            bus.gray_valid <= 1'b0;
            bus.gray_data  <= '0;
            bus.gray_bin   <= 1'b0;
            bus.gray_x     <= '0;
            bus.gray_y     <= '0;
        end else begin
            r_vs_d <= bus.dvp_vsync;
            r_hr_d <= bus.dvp_href;
            if (w_vs_rise) begin
                r_mode   <= bus.cfg_mode;
                r_bin_en <= bus.cfg_bin_en;
                r_thresh <= bus.cfg_thresh;
            end
            r_x <= w_hr_fall ? '0 : (bus.dvp_valid && bus.dvp_href && r_x != '1) ? r_x + X_W'(1) : r_x;
            r_y <= w_vs_rise ? '0 : (w_hr_fall && bus.dvp_vsync && r_y != '1) ? r_y + Y_W'(1) : r_y;
            r1_ctl    <= {bus.dvp_vsync, bus.dvp_href, bus.dvp_valid};
            r1_r      <= w_r8;
            r1_g      <= w_g8;
            r1_b      <= w_b8;
            r1_wr     <= w_wr;
            r1_wg     <= w_wg;
            r1_wb     <= w_wb;
            r1_x      <= r_x;
            // A pixel in the vsync-rise cycle belongs to line 0 of the new frame.
            r1_y      <= w_vs_rise ? '0 : r_y;
            r1_bin_en <= w_bin_en;
            r1_thresh <= w_thresh;
            r2_ctl    <= r1_ctl;
            r2_pr     <= {8'd0, r1_r} * {7'd0, r1_wr};
            r2_pg     <= {8'd0, r1_g} * {7'd0, r1_wg};
            r2_pb     <= {8'd0, r1_b} * {7'd0, r1_wb};
            r2_x      <= r1_x;
            r2_y      <= r1_y;
            r2_bin_en <= r1_bin_en;
            r2_thresh <= r1_thresh;
            bus.gray_vsync <= r2_ctl[2];
            bus.gray_href  <= r2_ctl[1];
            bus.gray_valid <= r2_ctl[0];
            if (r2_ctl[0]) begin
                bus.gray_data <= r2_bin_en ? {OUT_W{w_bin}} : w_gray;
                bus.gray_bin  <= w_bin;
                bus.gray_x    <= r2_x;
                bus.gray_y    <= r2_y;
            end
        end
    end
endmodule

// File: tb/tb_gray_convert_cfg.sv
// tb_gray_convert_cfg: scoreboard bench for three converter variants (trunc/8, round/8, trunc/10)
module tb_gray_convert_cfg;
    typedef struct packed {
        logic        vs, hr, vd;
        logic [7:0]  d0, d1;
        logic [9:0]  d2;
        logic        b0, b1, b2;
        logic [10:0] x;
        logic [9:0]  y;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b0, hr = 1'b0, vd = 1'b0;
    logic [15:0] dat = '0;
    logic [1:0]  cfg_mode = '0;
    logic        cfg_bin_en = 1'b0;
    logic [9:0]  cfg_thresh = '0;
    int          n_tot = 0, n_bad = 0;
    exp_t        q[$];
    logic        m_vs_d, m_hr_d, m_bin;
    logic [1:0]  m_mode;
    int          m_th, m_x, m_y;
    exp_t        h;
    logic [15:0] pat[4]  = '{16'hFFFF, 16'hF800, 16'h0400, 16'h8410};
    logic [15:0] pat2[4] = '{16'hFFFF, 16'h0000, 16'h8410, 16'hF800};
    always #5 clk = ~clk;
    gray_convert_cfg_if #(.DATA_W(16), .OUT_W(8),  .X_W(11), .Y_W(10)) if0 ();
    gray_convert_cfg_if #(.DATA_W(16), .OUT_W(8),  .X_W(11), .Y_W(10)) if1 ();
    gray_convert_cfg_if #(.DATA_W(16), .OUT_W(10), .X_W(11), .Y_W(10)) if2 ();
    assign if0.dvp_vsync = vs;  assign if1.dvp_vsync = vs;  assign if2.dvp_vsync = vs;
    assign if0.dvp_href  = hr;  assign if1.dvp_href  = hr;  assign if2.dvp_href  = hr;
    assign if0.dvp_valid = vd;  assign if1.dvp_valid = vd;  assign if2.dvp_valid = vd;
    assign if0.dvp_data  = dat; assign if1.dvp_data  = dat; assign if2.dvp_data  = dat;
    assign if0.cfg_mode  = cfg_mode;   assign if1.cfg_mode  = cfg_mode;   assign if2.cfg_mode  = cfg_mode;
    assign if0.cfg_bin_en = cfg_bin_en; assign if1.cfg_bin_en = cfg_bin_en; assign if2.cfg_bin_en = cfg_bin_en;
    assign if0.cfg_thresh = cfg_thresh[7:0]; assign if1.cfg_thresh = cfg_thresh[7:0]; assign if2.cfg_thresh = cfg_thresh;
    gray_convert_cfg #(.DATA_W(16), .OUT_W(8),  .X_W(11), .Y_W(10), .ROUND(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    gray_convert_cfg #(.DATA_W(16), .OUT_W(8),  .X_W(11), .Y_W(10), .ROUND(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    gray_convert_cfg #(.DATA_W(16), .OUT_W(10), .X_W(11), .Y_W(10), .ROUND(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    function automatic int gray_of(input logic [15:0] d, input logic [1:0] m, input int rnd, input int ow);
        logic [7:0] r8, g8, b8;
        int wr, wg, wb, s;
        r8 = {d[15:11], d[15:13]};
        g8 = {d[10:5], d[10:9]};
        b8 = {d[4:0], d[4:2]};
        case (m)
            2'd0: begin wr = 77; wg = 150; wb = 29; end
            2'd1: begin wr = 54; wg = 183; wb = 19; end
            2'd2: begin wr = 85; wg = 86;  wb = 85; end
            default: begin wr = 0; wg = 256; wb = 0; end
        endcase
        s = int'(r8) * wr + int'(g8) * wg + int'(b8) * wb;
        if (rnd != 0) s += 1 << (15 - ow);
        return s >> (16 - ow);
    endfunction

    function automatic int shape(input int g, input int ow);
        return m_bin ? ((g >= m_th) ? (1 << ow) - 1 : 0) : g;
    endfunction

    task automatic mreset();
        m_vs_d = 1'b0; m_hr_d = 1'b0; m_bin = 1'b0; m_mode = '0;
        m_th = 0; m_x = 0; m_y = 0; h = '0;
    endtask

    task automatic model();
        logic rise, fall;
        int g0, g1, g2;
        exp_t e;
        rise = vs && !m_vs_d;
        fall = m_hr_d && !hr;
        if (rise) begin
            m_mode = cfg_mode; m_bin = cfg_bin_en; m_th = int'(cfg_thresh);
        end
        if (vd) begin
            g0 = gray_of(dat, m_mode, 0, 8);
            g1 = gray_of(dat, m_mode, 1, 8);
            g2 = gray_of(dat, m_mode, 0, 10);
            h.d0 = 8'(shape(g0, 8));
            h.d1 = 8'(shape(g1, 8));
            h.d2 = 10'(shape(g2, 10));
            h.b0 = g0 >= m_th;
            h.b1 = g1 >= m_th;
            h.b2 = g2 >= m_th;
            h.x  = 11'(m_x);
            h.y  = rise ? 10'd0 : 10'(m_y);
        end
        e = h;
        e.vs = vs; e.hr = hr; e.vd = vd;
        q.push_back(e);
        m_x = fall ? 0 : (vd && hr && m_x < 2047) ? m_x + 1 : m_x;
        m_y = rise ? 0 : (fall && vs && m_y < 1023) ? m_y + 1 : m_y;
        m_vs_d = vs;
        m_hr_d = hr;
    endtask

    task automatic step(input logic v_s, input logic h_r, input logic v_d, input logic [15:0] d);
        @(posedge clk);
        #1;
        vs = v_s; hr = h_r; vd = v_d; dat = d;
        model();
    endtask

    task automatic line4(input logic [15:0] p[4]);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, p[i]);
        step(1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (q.size() >= 4) begin
            e = q.pop_front();
            check("vsync", 32'(if0.gray_vsync), 32'(e.vs));
            check("href",  32'(if0.gray_href),  32'(e.hr));
            check("valid", 32'(if0.gray_valid), 32'(e.vd));
            check("data0", 32'(if0.gray_data),  32'(e.d0));
            check("data1", 32'(if1.gray_data),  32'(e.d1));
            check("data2", 32'(if2.gray_data),  32'(e.d2));
            check("bin0",  32'(if0.gray_bin),   32'(e.b0));
            check("bin1",  32'(if1.gray_bin),   32'(e.b1));
            check("bin2",  32'(if2.gray_bin),   32'(e.b2));
            check("x",     32'(if0.gray_x),     32'(e.x));
            check("y",     32'(if0.gray_y),     32'(e.y));
        end
    end

    initial begin
        mreset();
        repeat (3) q.push_back('0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        // frame A, mode 0, mode change mid-frame ignored
        step(1'b1, 1'b0, 1'b0, 16'h0);
        line4(pat);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b1, pat[i]);
            step(1'b1, 1'b1, 1'b0, 16'h0);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0);
        cfg_mode = 2'd3;
        repeat (3) step(1'b1, 1'b1, 1'b1, 16'hF800);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        // frame B, mode 3 taken on the rise, pixel in the edge cycle
        step(1'b1, 1'b1, 1'b1, 16'hF800);
        step(1'b1, 1'b1, 1'b1, 16'h0400);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        // frame C, binarize at 128
        cfg_mode = 2'd0; cfg_bin_en = 1'b1; cfg_thresh = 10'd128;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        line4(pat2);
        line4(pat);
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        // modes 1 and 2 with random pixels and valid gaps
        cfg_bin_en = 1'b0; cfg_thresh = 10'd0;
        for (int m = 1; m < 3; m++) begin
            cfg_mode = 2'(m);
            step(1'b1, 1'b0, 1'b0, 16'h0);
            for (int l = 0; l < 3; l++) begin
                for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom));
                step(1'b1, 1'b0, 1'b0, 16'h0);
            end
            repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        end
        // counter saturation: one long line, then many short lines
        cfg_mode = 2'd0;
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 2052; i++) step(1'b1, 1'b1, 1'b1, 16'($urandom));
        step(1'b1, 1'b0, 1'b0, 16'h0);
        for (int l = 0; l < 1030; l++) begin
            step(1'b1, 1'b1, 1'b1, 16'($urandom));
            step(1'b1, 1'b0, 1'b0, 16'h0);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0);
        // frame with reset in the middle of line 1
        step(1'b1, 1'b0, 1'b0, 16'h0);
        line4(pat);
        step(1'b1, 1'b1, 1'b1, 16'hFFFF);
        step(1'b1, 1'b1, 1'b1, 16'hF800);
        #1;
        rst_n = 1'b0;
        q.delete();
        repeat (4) q.push_back('0);
        mreset();
        vs = 1'b0; hr = 1'b0; vd = 1'b0; dat = '0;
        #1;
        check("rst_vsync", 32'(if0.gray_vsync), 32'd0);
        check("rst_valid", 32'(if0.gray_valid), 32'd0);
        check("rst_data",  32'(if0.gray_data),  32'd0);
        check("rst_x",     32'(if0.gray_x),     32'd0);
        check("rst_y",     32'(if0.gray_y),     32'd0);
        cfg_mode = 2'd3;
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
        // reset config (mode 0) still active; valid outside href yields output at x=0
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, pat[i]);
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b0, 16'h0);
        line4(pat);
        line4(pat2);
        repeat (6) step(1'b0, 1'b0, 1'b0, 16'h0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/gray_convert_cfg.md
GRAY_CONVERT_CFG -- requirements
Module: gray_convert_cfg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning input pixel width: 16 = RGB565 {R5,G6,B5}, 24 = RGB888 {R8,G8,B8}; other values are illegal.
REQ-002 The block SHALL have parameter OUT_W, default 8, meaning gray output width, legal range 8..10.
REQ-003 The block SHALL have parameters X_W, default 11, and Y_W, default 10, meaning the pixel and line coordinate counter widths.
REQ-004 The block SHALL have parameter ROUND, default 0: 0 = truncate, 1 = round half up.
REQ-005 clk  in  1  the single clock; all flops are rising-edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 dvp_vsync  in  1  frame active, high during the frame; dvp_href  in  1  line active; dvp_valid  in  1  pixel valid.
REQ-008 dvp_data  in  DATA_W  RGB pixel, qualified by dvp_valid.
REQ-009 cfg_mode  in  2  weight set: 0 = BT.601 (77,150,29); 1 = BT.709 (54,183,19); 2 = average (85,86,85); 3 = green-only (0,256,0).
REQ-010 cfg_bin_en  in  1  binarize enable; cfg_thresh  in  OUT_W  binarize threshold.
REQ-011 gray_vsync, gray_href, gray_valid  out  1 each  the input controls delayed by exactly 3 cycles.
REQ-012 gray_data  out  OUT_W  gray or binarized pixel; gray_bin  out  1  threshold result.
REQ-013 gray_x  out  X_W  and gray_y  out  Y_W  coordinates of the output pixel.

Function
REQ-014 Channel expansion to 8 bits SHALL use MSB replication: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}; RGB888 channels pass through unchanged.
REQ-015 The pipeline SHALL have 3 stages (expand + weight select; three 8x9 multiplies; sum + round + threshold), with fixed latency of 3 for data, controls and coordinates, no backpressure, and one pixel per clock sustained.
REQ-016 sum SHALL be R8*wR + G8*wG + B8*wB, 16 bits; gray = sum[15:16-OUT_W], or with ROUND=1, (sum + 2^(15-OUT_W))[15:16-OUT_W]; max 65280+128 < 65536, so no overflow or saturation is needed.
REQ-017 Active config (mode, bin_en, thresh) SHALL be loaded only on a dvp_vsync rising edge (dvp_vsync=1, previous-cycle dvp_vsync=0); the pixel in the edge cycle uses the new config; cfg changes mid-frame are ignored.
REQ-018 gray_bin SHALL be (gray >= active thresh); when active bin_en=1, gray_data SHALL be all-ones if gray_bin else 0; when bin_en=0, gray_data = gray.
REQ-019 x counter: SHALL increment per dvp_valid pixel while dvp_href=1; SHALL clear on dvp_href falling edge; saturates at 2^X_W-1; pixel coordinate = count before increment.
REQ-020 y counter: SHALL increment on each dvp_href falling edge while dvp_vsync=1; SHALL clear on dvp_vsync rising edge (the edge wins over a simultaneous href fall); saturates at 2^Y_W-1.
REQ-021 gray_data, gray_bin, gray_x and gray_y SHALL update only on cycles where gray_valid=1 and otherwise hold.
REQ-022 dvp_valid with dvp_href=0 SHALL still produce output; the coordinate is the current x, and x does not increment.

Reset
REQ-023 On rst_n=0, all outputs, pipeline registers and counters SHALL be 0, and the active config SHALL be mode 0, bin_en 0, thresh 0, taking effect immediately and asynchronously.
REQ-024 Reset mid-frame SHALL drop in-flight pixels; after release, output SHALL stay 0 until new input propagates (3 cycles); config reloads only at the next vsync rise.

Verification
REQ-025 DATA_W=16, mode 0, ROUND=0: 0xFFFF -> gray_data 255 three cycles later; 0xF800 -> 76; with ROUND=1, 0xF800 -> 77.
REQ-026 Mode 3: 0x0400 (G8=130) -> 130; OUT_W=10, mode 0: 0xFFFF -> 1020.
REQ-027 Frame with cfg_mode=0; set cfg_mode=3 mid-frame -> 0xF800 still gives 76; after the next vsync rise it gives 0.
REQ-028 bin_en=1, thresh=128: 0xFFFF -> gray_data 255, gray_bin 1; 0x0000 -> 0, gray_bin 0; 0x8410 (gray 130) -> 255.
REQ-029 Two lines of 4 valid pixels each -> gray_x 0..3, gray_y 0 then 1; last pixel (3,1); next vsync rise -> y returns to 0.
REQ-030 Assert rst_n low during the line-1 pixel stream -> all outputs 0 asynchronously; a released, clean next frame restarts at (0,0) in mode 0 unless cfg differs at the vsync rise.
